gpu_ddr_avalon_bridge: RTL

GPU_DDR_AVALON_BRIDGE -- requirements
Module: gpu_ddr_avalon_bridge

---
 rtl/gpu_ddr_avalon_bridge.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/gpu_ddr_avalon_bridge.sv
// Bridges the PSX GPU VRAM port onto an Avalon-MM burst master with an in-order request FIFO.
// Optional performance counters are built when GPU_DDR_BRIDGE_PERF_EN is defined.
module gpu_ddr_avalon_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_RD_BEATS = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [16:0] i_targetAddr,
    input  logic [2:0]  i_burstLength,
    input  logic        i_writeEnableMem,
    input  logic        i_readEnableMem,
    input  logic [63:0] i_dataMem,
    input  logic [7:0]  i_byteEnableMem,
    output logic        o_busyMem,
    output logic        o_dataValidMem,
    output logic [63:0] o_dataMem,
    output logic [31:0] o_avm_address,
    output logic [2:0]  o_avm_burstcount,
    output logic        o_avm_write,
    output logic        o_avm_read,
    output logic [63:0] o_avm_writedata,
    output logic [7:0]  o_avm_byteenable,
    input  logic        i_avm_waitrequest,
    input  logic        i_avm_readdatavalid,
    input  logic [63:0] i_avm_readdata
`ifdef GPU_DDR_BRIDGE_PERF_EN
    , output logic [31:0] o_perf_rdBeats
    , output logic [31:0] o_perf_wrBeats
    , output logic [31:0] o_perf_stallCycles
`endif
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] BUSY_TH = CW'(FIFO_DEPTH - 1);
    localparam logic [7:0]    MAX_RD  = 8'(MAX_RD_BEATS);

    typedef struct packed {
        logic        wr;
        logic [16:0] addr;
        logic [2:0]  burst;
        logic [63:0] data;
        logic [7:0]  be;
        logic        first;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WBURST} state_t;

    function automatic logic [2:0] norm_burst(input logic [2:0] b);
        if (b == 3'd0)      return 3'd1;
        else if (b > 3'd4)  return 3'd4;
        else                return b;
    endfunction

    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        push_entry, head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt, cnt_next;
    logic          push, pop, fifo_empty, busy_q;
    logic [2:0]    up_left;

    state_t        state, state_next;
    logic          load_wr, issue_rd, wr_beat_done;
    logic [31:0]   head_byte_addr, wr_addr_q;
    logic [2:0]    wr_burst_q, wr_left_q;

    logic [6:0]    rd_out, rd_next, drain, drain_base, drain_next;
    logic          rst_q, fwd;

    assign o_busyMem      = busy_q;
    assign fifo_empty     = (fifo_cnt == '0);
    assign head           = fifo_mem[rd_ptr];
    assign head_byte_addr = BASE_ADDR + {12'd0, head.addr, 3'b000};
    assign push           = (i_writeEnableMem | i_readEnableMem) & ~busy_q & ~i_rst;

    // Continuation write beats reuse the entry layout; only data/be matter for them.
    always_comb begin
        push_entry       = '0;
        push_entry.wr    = i_writeEnableMem;
        push_entry.addr  = i_targetAddr;
        push_entry.burst = norm_burst(i_burstLength);
        push_entry.data  = i_dataMem;
        push_entry.be    = i_byteEnableMem;
        push_entry.first = ~(i_writeEnableMem & (up_left != 3'd0));
    end

    always_comb begin
        cnt_next = fifo_cnt;
        if (push && !pop)      cnt_next = fifo_cnt + 1'b1;
        else if (pop && !push) cnt_next = fifo_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            busy_q   <= 1'b1;
            up_left  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= cnt_next;
            busy_q   <= (cnt_next >= BUSY_TH);
            if (push && i_writeEnableMem)
                up_left <= (up_left == 3'd0) ? norm_burst(i_burstLength) - 3'd1 : up_left - 3'd1;
        end
    end

    always_comb begin
        state_next       = state;
        pop              = 1'b0;
        load_wr          = 1'b0;
        issue_rd         = 1'b0;
        wr_beat_done     = 1'b0;
        o_avm_read       = 1'b0;
        o_avm_write      = 1'b0;
        o_avm_address    = 32'd0;
        o_avm_burstcount = 3'd0;
        o_avm_writedata  = 64'd0;
        o_avm_byteenable = 8'd0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head.wr && !head.first) begin
                        pop = 1'b1;  // orphaned continuation beat, nothing to attach it to
                    end else if (head.wr) begin
                        load_wr    = 1'b1;
                        state_next = S_WBURST;
                    end else if (({1'b0, rd_out} + {5'd0, head.burst}) <= MAX_RD) begin
                        state_next = S_RD;
                    end
                end
            end
            S_RD: begin
                o_avm_read       = 1'b1;
                o_avm_address    = head_byte_addr;
                o_avm_burstcount = head.burst;
                if (!i_avm_waitrequest) begin
                    pop        = 1'b1;
                    issue_rd   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_WBURST: begin
                o_avm_write      = ~fifo_empty;
                o_avm_address    = wr_addr_q;
                o_avm_burstcount = wr_burst_q;
                if (!fifo_empty) begin
                    o_avm_writedata  = head.data;
                    o_avm_byteenable = head.be;
                    if (!i_avm_waitrequest) begin
                        pop          = 1'b1;
                        wr_beat_done = 1'b1;
                        if (wr_left_q == 3'd1) state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            wr_left_q <= 3'd0;
        end else begin
            state <= state_next;
            if (load_wr)           wr_left_q <= head.burst;
            else if (wr_beat_done) wr_left_q <= wr_left_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_wr) begin
            wr_addr_q  <= head_byte_addr;
            wr_burst_q <= head.burst;
        end
    end

    // Beats owed to reads issued before a reset are swallowed via the drain counter.
    assign fwd = i_avm_readdatavalid & (drain == 7'd0) & ~i_rst;

    always_comb begin
        rd_next = rd_out + (issue_rd ? {4'd0, head.burst} : 7'd0);
        if (fwd && rd_next != 7'd0) rd_next = rd_next - 7'd1;
        drain_base = drain;
        if (i_rst && !rst_q)
            drain_base = drain + rd_out + (issue_rd ? {4'd0, head.burst} : 7'd0);
        drain_next = drain_base;
        if (i_avm_readdatavalid && drain_base != 7'd0) drain_next = drain_base - 7'd1;
    end

    always_ff @(posedge clk) begin
        rst_q <= i_rst;
        drain <= drain_next;
        if (i_rst) begin
            rd_out         <= 7'd0;
            o_dataValidMem <= 1'b0;
            o_dataMem      <= 64'd0;
        end else begin
            rd_out         <= rd_next;
            o_dataValidMem <= fwd;
            if (fwd) o_dataMem <= i_avm_readdata;
        end
    end

`ifdef GPU_DDR_BRIDGE_PERF_EN
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_perf_rdBeats     <= 32'd0;
            o_perf_wrBeats     <= 32'd0;
            o_perf_stallCycles <= 32'd0;
        end else begin
            if (i_avm_readdatavalid) o_perf_rdBeats <= o_perf_rdBeats + 32'd1;
            if (wr_beat_done)        o_perf_wrBeats <= o_perf_wrBeats + 32'd1;
            if ((o_avm_read | o_avm_write) && i_avm_waitrequest)
                o_perf_stallCycles <= o_perf_stallCycles + 32'd1;
        end
    end
`endif

endmodule
